// File: rtl/alu_multicycle.sv
// Execute-stage ALU with a valid/ready result handshake.
// Logic, arithmetic and compare ops finish in one registered cycle; shifts
// move one bit per cycle unless ALU_BARREL_SHIFT_EN is defined, in which case
// a combinational barrel shifter makes them single-cycle too.
module alu_multicycle #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_BNE = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_BGE = 4'b1101;
    localparam logic [3:0] OP_BLT = 4'b1110;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL_EN = 1'b1;
`else
    localparam bit BARREL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   work_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [3:0]          sop_q;

    logic                accept_c;
    logic                is_shift_c;
    logic                start_shift_c;
    logic                last_shift_c;
    logic [SHAMT_W-1:0]  shamt_c;
    logic [DATA_W-1:0]   comb_result_c;
    logic [DATA_W-1:0]   shift1_c;

    // Single-cycle result; for shifts this is only used when no iteration is needed
    function automatic logic [DATA_W-1:0] alu_fn(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
`ifdef ALU_BARREL_SHIFT_EN
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
`endif
        r = '0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL: r = a << sh;
            OP_SRL: r = a >> sh;
            OP_SRA: r = DATA_W'($signed(a) >>> sh);
`else
            OP_SLL: r = a;
            OP_SRL: r = a;
            OP_SRA: r = a;
`endif
            OP_SLT: r = DATA_W'($signed(a) < $signed(b));
            OP_BLT: r = DATA_W'($signed(a) < $signed(b));
            OP_BGE: r = DATA_W'(!($signed(a) < $signed(b)));
            OP_BEQ: r = DATA_W'(a == b);
            OP_BNE: r = DATA_W'(a != b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // One-bit step of the iterative shifter
    function automatic logic [DATA_W-1:0] shift1(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] w
    );
        logic [DATA_W-1:0] r;
        r = w;
        case (op)
            OP_SLL:  r = {w[DATA_W-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[DATA_W-1:1]};
            OP_SRA:  r = {w[DATA_W-1], w[DATA_W-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Accept decode and datapath helpers
    always_comb begin
        shamt_c       = SrcB[SHAMT_W-1:0];
        is_shift_c    = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                        (Operation == OP_SRA);
        accept_c      = in_valid && in_ready;
        start_shift_c = accept_c && is_shift_c && (shamt_c != '0) && !BARREL_EN;
        last_shift_c  = (cnt_q <= SHAMT_W'(1));
        comb_result_c = alu_fn(Operation, SrcA, SrcB);
        shift1_c      = shift1(sop_q, work_q);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = start_shift_c ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last_shift_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept_c) begin
                    state_d = start_shift_c ? ST_SHIFT : ST_DONE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand capture, shift iteration and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sop_q    <= '0;
        end else if (accept_c) begin
            if (start_shift_c) begin
                work_q <= SrcA;
                cnt_q  <= shamt_c;
                sop_q  <= Operation;
            end else begin
                result_q <= comb_result_c;
            end
        end else if (state_q == ST_SHIFT) begin
            work_q <= shift1_c;
            cnt_q  <= cnt_q - SHAMT_W'(1);
            if (last_shift_c) begin
                result_q <= shift1_c;
            end
        end
    end

    assign ALUResult = result_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vectors, handshake corner sequences and
// random operations scored against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int unsigned DW = 32;
`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    Operation;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ALUResult;
    logic          busy;

    always #5 clk = ~clk;

    alu_multicycle #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b1001: return a ^ b;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b0111: return 32'($signed(a) >>> sh);
            4'b1100, 4'b1110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1101: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1010: return (a != b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
        bit is_shift;
        is_shift = (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0111);
        if (is_shift && !BARREL && (b % 32) != 0) return int'(b % 32) + 1;
        return 1;
    endfunction

    // Issue one op at a negedge with out_ready high; return at the negedge where out_valid is seen
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busyc);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        Operation = 4'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
        lat   = 1;
        busyc = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busyc++;
            @(negedge clk);
            lat++;
        end
        res = ALUResult;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] res;
        int          lat;
        int          busyc;
        int          seen;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{4'b0011, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE});
        vecs.push_back('{4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000});
        vecs.push_back('{4'b0101, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234});
        vecs.push_back('{4'b1110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
        vecs.push_back('{4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{4'b1100, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001});
        vecs.push_back('{4'b1010, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000});
        vecs.push_back('{4'b1001, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F});
        vecs.push_back('{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000});
        vecs.push_back('{4'b0001, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0});
        vecs.push_back('{4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000});
        vecs.push_back('{4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001});
        vecs.push_back('{4'b0111, 32'h4000_0000, 32'h0000_0003, 32'h0800_0000});
        vecs.push_back('{4'b0100, 32'h0000_0003, 32'h0000_0022, 32'h0000_000C});
        vecs.push_back('{4'b1100, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001});
        vecs.push_back('{4'b1100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000});
        vecs.push_back('{4'b1110, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{4'b1101, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001});
        vecs.push_back('{4'b0110, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000});
        vecs.push_back('{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Operation = 4'b0000;
        SrcA      = '0;
        SrcB      = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Back-to-back ADD then SUB with out_ready held high
        chk("b2b_in_ready0", 32'(in_ready), 32'd1);
        Operation = 4'b0010; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_add_valid", 32'(out_valid), 32'd1);
        chk("b2b_add_result", ALUResult, 32'h0000_0000);
        chk("b2b_in_ready1", 32'(in_ready), 32'd1);
        Operation = 4'b0011; SrcA = 32'd5; SrcB = 32'd7;
        @(negedge clk);
        chk("b2b_sub_valid", 32'(out_valid), 32'd1);
        chk("b2b_sub_result", ALUResult, 32'hFFFF_FFFE);
        chk("b2b_in_ready2", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busyc);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(model_latency(vecs[i].op, vecs[i].b)));
            chk($sformatf("vec%0d_busy", i), 32'(busyc), 32'(model_latency(vecs[i].op, vecs[i].b) - 1));
        end

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            run_op(rop, ra, rb, res, lat, busyc);
            chk($sformatf("rnd%0d_op%h_result", i, rop), res, model_result(rop, ra, rb));
            chk($sformatf("rnd%0d_op%h_latency", i, rop), 32'(lat), 32'(model_latency(rop, rb)));
        end

        // Backpressure: result held while a new op waits
        @(negedge clk);
        out_ready = 1'b0;
        Operation = 4'b1001; SrcA = 32'h0000_00F0; SrcB = 32'h0000_00FF; in_valid = 1'b1;
        @(negedge clk);
        Operation = 4'b0010; SrcA = 32'd2; SrcB = 32'd3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_result", i), ALUResult, 32'h0000_000F);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk("bp_hold_result", ALUResult, 32'h0000_000F);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_new_valid", 32'(out_valid), 32'd1);
        chk("bp_new_result", ALUResult, 32'd5);
        @(negedge clk);
        chk("bp_retired", 32'(out_valid), 32'd0);

        // Reset in the middle of a long shift
        Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd31; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), BARREL ? 32'd0 : 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_result", ALUResult, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy || !in_ready) seen++;
        end
        chk("postrst_idle_cycles_disturbed", 32'(seen), 32'd0);
        run_op(4'b0010, 32'd40, 32'd2, res, lat, busyc);
        chk("postrst_add_result", res, 32'd42);
        chk("postrst_add_latency", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, plus the SrcA and SrcB operands.
- Logic and arithmetic ops complete in one registered cycle.
- Shifts run iteratively, one bit per cycle, to save area.
- Results are returned over a valid/ready handshake so the pipeline can stall on long shifts.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; equals log2(DATA_W).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation and operands presented.
- in_ready  output  1  block can accept an operation.
- Operation  input  4  ALU operation code.
- SrcA  input  DATA_W  operand A.
- SrcB  input  DATA_W  operand B; SrcB[SHAMT_W-1:0] is the shift amount.
- out_valid  output  1  ALUResult valid.
- out_ready  input  1  consumer accepts the result.
- ALUResult  output  DATA_W  result.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset: asynchronous on reset_n low, released synchronously. State=IDLE, out_valid=0, ALUResult=0, busy=0, in_ready=1.
- Codes, unsigned unless stated:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A-B); 1001 XOR.
  - 0100 SLL; 0101 SRL; 0111 SRA.
  - 1100 SLT (signed, result 1/0).
  - 1000 BEQ (1 if A==B); 1010 BNE (1 if A!=B); 1110 BLT (1 if signed A<B); 1101 BGE (1 if signed A>=B).
  - All other codes give result 0, single-cycle.
- Arithmetic wraps modulo 2^DATA_W; no overflow flag.
- Accept: an operation is accepted when in_valid && in_ready at a clock edge. Operation and operands are captured, so inputs may change afterwards.
- States: IDLE, SHIFT, DONE.
  - IDLE, accept of a non-shift op: ALUResult is registered; go to DONE with out_valid=1 on the next cycle (latency 1).
  - IDLE, accept of a shift op with shamt=0: ALUResult=SrcA; go to DONE (latency 1).
  - IDLE, accept of a shift op with shamt=N>0: load the working register with SrcA and the counter with N; go to SHIFT.
  - SHIFT: each cycle shift the working register by 1 and decrement the counter. SLL fills 0 at the LSB; SRL fills 0 at the MSB; SRA replicates the MSB. On the cycle the counter reaches 0, register the result and go to DONE. Latency is N+1 cycles from accept to out_valid.
  - DONE: out_valid=1, ALUResult held stable until out_ready.
    - If out_ready and in_valid in the same cycle: retire the result and accept the new op, with the same transitions as IDLE. This allows back-to-back single-cycle ops at one per cycle.
    - If out_ready and no in_valid: go to IDLE with out_valid=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is low throughout SHIFT; in_valid is ignored there.
- busy = (state==SHIFT).
- ALUResult keeps its last value in IDLE; only the out_valid qualification matters.
- reset_n asserted mid-SHIFT or in DONE aborts the operation immediately. The result is lost and all outputs take their reset values.
- in_ready must not depend combinationally on in_valid. out_valid must not depend combinationally on out_ready.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- When defined: shifts use a combinational barrel shifter and complete in 1 cycle like all other ops. The SHIFT state is never entered and busy stays 0.
- When undefined: shifts are iterative as described above.
- The port list is identical in both builds.

Test Plan:
- Reset mid-operation: hold reset_n low, release, accept SLL A=1, B=31, assert reset_n low 5 cycles later -> outputs return asynchronously to reset values; after release in_ready=1 and no stale out_valid appears.
- ADD then SUB back-to-back with out_ready=1: ADD A=0xFFFFFFFF, B=1, then SUB A=5, B=7 -> ALUResult=0x00000000 one cycle after the first accept, then 0xFFFFFFFE the next cycle, with in_ready=1 throughout.
- SRA iterative shift: A=0x80000000, B=4 -> busy=1 for 4 cycles, in_ready=0 during those cycles, out_valid on the cycle after the 4th shift (5 cycles after accept), ALUResult=0xF8000000. With ALU_BARREL_SHIFT_EN defined, the same result arrives 1 cycle after accept.
- Zero-amount shift: SRL A=0x1234, B=0x20 (shamt=0) -> ALUResult=0x1234 after 1 cycle; busy stays 0.
- Branch and SLT compares: BLT A=0xFFFFFFFF, B=1 -> 1; BGE on the same operands -> 0; SLT A=-3, B=-2 -> 1; BEQ A=B=7 -> 1; BNE A=B=7 -> 0.
- Backpressure: complete XOR A=0xF0, B=0xFF with out_ready=0 for 3 cycles while in_valid=1 with a new op -> ALUResult=0x0F held stable, out_valid=1, in_ready=0, new op not accepted. Raise out_ready -> result retires and the new op is accepted on the same edge.
